mod_mul_radix_stream: RTL
=========================

// Module: mod_mul_radix_stream
// PURPOSE
// - Streaming modular multiplier: P = A*B mod M, MSB-first interleaved (shift-add-reduce) algorithm.
// - Processes RADIX_K bits of B per clock, so latency is a fixed ceil(DATA_W/RADIX_K) cycles.
// - Valid/ready handshake on both sides and an operand range check with an error flag.
// - Sits between the operand scheduler and the result FIFO in the modular-arithmetic datapath.
// PARAMETERS
// - DATA_W   256  operand / modulus / result width in bits
// - RADIX_K  1    B bits consumed per cycle (1..DATA_W); K bit-steps are chained combinationally
// - TAG_W    8    width of the opaque tag carried from request to result
// PORTS
// - i_clk        in   1       system clock, rising edge
// - i_rst_n      in   1       reset, asynchronous assert, active-low
// - i_clear      in   1       synchronous abort: drop any job and return to IDLE
// - i_valid      in   1       request valid
// - o_in_ready   out  1       request accepted on an edge where i_valid && o_in_ready
// - i_a          in   DATA_W  operand A, must be < M
// - i_b          in   DATA_W  operand B, must be < M
// - i_m          in   DATA_W  modulus M, must be odd and >= 3
// - i_tag        in   TAG_W   request tag
// - o_valid      out  1       result valid
// - i_ready      in   1       result consumed on an edge where o_valid && i_ready
// - o_p          out  DATA_W  result A*B mod M (0 when o_err = 1)
// - o_err        out  1       operand violation for this result; qualified by o_valid
// - o_tag        out  TAG_W   tag of the accepted request
// - o_busy       out  1       high in CALC
// BEHAVIOUR
// - Reset and i_clear:
//   - Reset gives state = IDLE and drives o_valid = 0, o_err = 0, o_busy = 0, o_p = 0, o_tag = 0.
//   - o_in_ready = 1 after reset.
//   - Reset mid-job discards the job; no result is produced.
//   - i_clear has priority over all other events and has the same effect as reset on state and outputs.
// - N_ITER = ceil(DATA_W/RADIX_K). B is zero-extended to N_ITER*RADIX_K bits; the leading zeros do not change the result.
// - State machine IDLE -> CALC -> DONE:
//   - IDLE: o_in_ready = 1.
//     - On accept, latch A, B, M and tag, and clear P.
//     - If M is even, M < 3, A >= M or B >= M: go to DONE with o_err = 1 and o_p = 0 (computation skipped).
//     - Otherwise clear the iteration counter and go to CALC.
//   - CALC: o_busy = 1, o_in_ready = 0.
//     - Each edge performs RADIX_K bit-steps on B, MSB first, then increments the counter.
//     - After the N_ITER-th edge: go to DONE and register the result.
//   - DONE: o_valid = 1. o_p, o_err and o_tag are held stable until the handshake.
//     - o_in_ready = 0.
//     - On i_ready, go to IDLE with o_valid = 0 the next cycle. No same-cycle re-accept.
// - Bit-step, with invariant P < M:
//   - T = 2P; if T >= M then T = T - M.
//   - If b_i = 1: U = T + A; if U >= M then U = U - M.
//   - P = U.
//   - Internal width is DATA_W+1 bits (2P < 2M and T + A < 2M). Compare by subtract and borrow sign.
// - Latency and throughput:
//   - o_valid rises exactly N_ITER edges after the accept edge, or 1 edge after it for an error.
//   - Peak throughput is one result per N_ITER+2 cycles.
// - i_valid while not ready: ignored. Requests are never queued.
// - Inputs i_a, i_b, i_m, i_tag are sampled only at the accept edge and may change freely afterwards.
// TESTING
// - W=8,K=1: A=5,B=7,M=13 -> o_p=9, o_err=0, o_valid exactly 8 edges after accept, tag echoed.
// - W=8,K=4: A=200,B=250,M=251 -> o_p=51, o_valid 2 edges after accept. K=3: same result, 3 edges.
// - W=8: M=12 (even), and separately A=13,M=13 -> o_err=1, o_p=0, o_valid 1 edge after accept.
// - Hold i_ready=0 for 5 cycles in DONE: o_p/o_err/o_tag stable, o_in_ready=0, new i_valid ignored.
// - Assert i_rst_n=0 at CALC iteration 3, and separately i_clear=1 at iteration 3:
//   - Both give o_valid=0, o_busy=0, o_in_ready=1.
//   - A following job returns the correct result.
// - W=256, K in {1,4,16}: 1000 random odd M with A,B<M -> o_p matches a golden (A*B)%M model, B=0 and B=M-1 included.

Source files
------------

// File: rtl/mod_mul_radix_stream.sv
// Streaming modular multiplier P = A*B mod M using MSB-first interleaved
// shift-add-reduce, consuming RADIX_K bits of B per clock.
module mod_mul_radix_stream #(
  parameter int DATA_W  = 256,
  parameter int RADIX_K = 1,
  parameter int TAG_W   = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [DATA_W-1:0] i_m,
  input  logic [TAG_W-1:0]  i_tag,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_p,
  output logic              o_err,
  output logic [TAG_W-1:0]  o_tag,
  output logic              o_busy
);

  localparam int N_ITER = (DATA_W + RADIX_K - 1) / RADIX_K;
  localparam int BX_W   = N_ITER * RADIX_K;
  localparam int CNT_W  = $clog2(N_ITER + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ITER - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] m_q, m_d;
  logic [BX_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0] p_q, p_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] p_step;
  logic [DATA_W:0]   t_val, u_val;
  logic [DATA_W+1:0] t_sub, u_sub;
  logic              bad_req;

  // K chained bit-steps; every intermediate stays below M, so DATA_W+1 bits
  // hold 2P and T+A, and the extra top bit of the subtraction is the borrow.
  // NOTE: always_comb uses blocking '=' so each step sees the previous step's
  // value within the same evaluation; always_ff below uses '<=' only.
  always_comb begin
    p_step = p_q;
    t_val  = '0;
    u_val  = '0;
    t_sub  = '0;
    u_sub  = '0;
    for (int k = 0; k < RADIX_K; k++) begin
      t_val = {p_step, 1'b0};
      t_sub = {1'b0, t_val} - {2'b00, m_q};
      if (!t_sub[DATA_W+1]) t_val = t_sub[DATA_W:0];
      u_val = t_val;
      if (b_q[BX_W-1-k]) begin
        u_val = t_val + {1'b0, a_q};
        u_sub = {1'b0, u_val} - {2'b00, m_q};
        if (!u_sub[DATA_W+1]) u_val = u_sub[DATA_W:0];
      end
      p_step = u_val[DATA_W-1:0];
    end
  end

  assign bad_req = !i_m[0] || (i_m < DATA_W'(3)) || (i_a >= i_m) || (i_b >= i_m);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    b_d     = b_q;
    p_d     = p_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          a_d   = i_a;
          b_d   = BX_W'(i_b);
          m_d   = i_m;
          tag_d = i_tag;
          p_d   = '0;
          cnt_d = '0;
          if (bad_req) begin
            err_d   = 1'b1;
            res_d   = '0;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        p_d   = p_step;
        b_d   = b_q << RADIX_K;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          res_d   = p_step;
          err_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (i_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort wins over any handshake in the same cycle.
    if (i_clear) begin
      state_d = S_IDLE;
      res_d   = '0;
      err_d   = 1'b0;
      tag_d   = '0;
      cnt_d   = '0;
      p_d     = '0;
    end
  end

  // NOTE: the operand registers are reset along with the control state; they
  // are plain flops (no RAM), so this costs nothing and keeps outputs defined.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      m_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      tag_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      b_q     <= b_d;
      p_q     <= p_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      err_q   <= err_d;
    end
  end

  assign o_in_ready = (state_q == S_IDLE);
  assign o_busy     = (state_q == S_CALC);
  assign o_valid    = (state_q == S_DONE);
  assign o_p        = res_q;
  assign o_err      = err_q;
  assign o_tag      = tag_q;

endmodule
